// File: rtl/computer_system_multi_interval_timer.sv
// Multi-channel interval timer with per-channel prescaler, one-shot/continuous
// modes, snapshot capture and a global pending-interrupt view.
module computer_system_multi_interval_timer #(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 32,
    parameter int          PRE_W          = 8,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h00BEBC1F
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [$clog2(NUM_CH)+2:0] address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic                      irq,
    output logic [NUM_CH-1:0]         irq_vec
);

    typedef enum logic [2:0] {
        REG_STATUS   = 3'd0,
        REG_CONTROL  = 3'd1,
        REG_PERIOD   = 3'd2,
        REG_SNAPSHOT = 3'd3,
        REG_PRESCALE = 3'd4,
        REG_PENDING  = 3'd5
    } reg_e;

    localparam logic [CNT_W-1:0] RST_PERIOD = DEFAULT_PERIOD[CNT_W-1:0];

    logic [31:0]       ch_num;
    logic              wr_en;
    logic [31:0]       rd_mux;

    logic [CNT_W-1:0]  period   [NUM_CH];
    logic [CNT_W-1:0]  counter  [NUM_CH];
    logic [CNT_W-1:0]  snapshot [NUM_CH];
    logic [CNT_W-1:0]  cnt_step [NUM_CH];
    logic [PRE_W-1:0]  prescale [NUM_CH];
    logic [PRE_W-1:0]  pre_cnt  [NUM_CH];

    logic [NUM_CH-1:0] to, run, ito, cont, zero_q, reload_q;
    logic [NUM_CH-1:0] w_status, w_control, w_period, w_snap, w_pre;
    logic [NUM_CH-1:0] tick, cnt_zero, to_evt;

    assign ch_num = 32'(address) >> 3;
    assign wr_en  = chipselect & ~write_n;

    always_comb begin
        w_status  = '0;
        w_control = '0;
        w_period  = '0;
        w_snap    = '0;
        w_pre     = '0;
        tick      = '0;
        cnt_zero  = '0;
        to_evt    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_status[i]  = wr_en && (ch_num == i) && (address[2:0] == REG_STATUS);
            w_control[i] = wr_en && (ch_num == i) && (address[2:0] == REG_CONTROL);
            w_period[i]  = wr_en && (ch_num == i) && (address[2:0] == REG_PERIOD);
            w_snap[i]    = wr_en && (ch_num == i) && (address[2:0] == REG_SNAPSHOT);
            w_pre[i]     = wr_en && (ch_num == i) && (address[2:0] == REG_PRESCALE);
            tick[i]      = run[i] && (pre_cnt[i] == '0);
            cnt_zero[i]  = (counter[i] == '0);
            // Timeout is the arrival at zero, not the dwell there.
            to_evt[i]    = cnt_zero[i] && !zero_q[i];
            cnt_step[i]  = cnt_zero[i] ? period[i] : counter[i] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                period[i]   <= RST_PERIOD;
                counter[i]  <= RST_PERIOD;
                snapshot[i] <= '0;
                prescale[i] <= '0;
                pre_cnt[i]  <= '0;
            end
            to       <= '0;
            run      <= '0;
            ito      <= '0;
            cont     <= '0;
            zero_q   <= '0;
            reload_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                zero_q[i]   <= cnt_zero[i];
                reload_q[i] <= w_period[i];
                to[i]       <= to_evt[i] | (to[i] & ~(w_status[i] & writedata[0]));

                if (w_control[i]) begin
                    ito[i]  <= writedata[0];
                    cont[i] <= writedata[1];
                end
                if (w_period[i]) period[i]   <= writedata[CNT_W-1:0];
                if (w_pre[i])    prescale[i] <= writedata[PRE_W-1:0];
                if (w_snap[i])   snapshot[i] <= counter[i];

                if (reload_q[i]) begin
                    counter[i] <= period[i];
                    pre_cnt[i] <= prescale[i];
                end else if (tick[i]) begin
                    counter[i] <= cnt_step[i];
                    pre_cnt[i] <= prescale[i];
                end else if (run[i]) begin
                    pre_cnt[i] <= pre_cnt[i] - PRE_W'(1);
                end

                // START outranks STOP and the forced reload; one-shot ends on landing at zero.
                if (w_control[i] && writedata[2])
                    run[i] <= 1'b1;
                else if ((w_control[i] && writedata[3]) || reload_q[i])
                    run[i] <= 1'b0;
                else if (tick[i] && !cont[i] && (cnt_step[i] == '0))
                    run[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_num == i) begin
                case (address[2:0])
                    REG_STATUS:   rd_mux = {30'd0, run[i], to[i]};
                    REG_CONTROL:  rd_mux = {30'd0, cont[i], ito[i]};
                    REG_PERIOD:   rd_mux = 32'(period[i]);
                    REG_SNAPSHOT: rd_mux = 32'(snapshot[i]);
                    REG_PRESCALE: rd_mux = 32'(prescale[i]);
                    REG_PENDING:  rd_mux = 32'(to);
                    default:      rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

    assign irq_vec = to & ito;
    assign irq     = |irq_vec;

endmodule

// File: tb/tb_computer_system_multi_interval_timer.sv
// Directed bench for the multi-channel interval timer: a register-access vector
// table followed by hand-timed sequences for counting, modes and corner cases.
module tb_computer_system_multi_interval_timer;

    localparam int AW = 5;
    localparam int R_STATUS = 0, R_CONTROL = 1, R_PERIOD = 2, R_SNAPSHOT = 3;
    localparam int R_PRESCALE = 4, R_PENDING = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [AW-1:0] address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic          irq;
    logic [3:0]    irq_vec;

    int n_vec = 0;
    int n_bad = 0;

    computer_system_multi_interval_timer #(
        .NUM_CH(4), .CNT_W(32), .PRE_W(8), .DEFAULT_PERIOD(32'h00BEBC1F)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        int          ch;
        int          rg;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(bit w, int ch, int rg, logic [31:0] wd, logic [31:0] exp);
        vec_t v;
        v.w = w; v.ch = ch; v.rg = rg; v.wd = wd; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit w, input int ch, input int rg, input logic [31:0] wd);
        address    = AW'(ch * 8 + rg);
        chipselect = w;
        write_n    = !w;
        writedata  = wd;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] wd);
        cyc(1'b1, ch, rg, wd);
    endtask

    task automatic rd(input int ch, input int rg);
        cyc(1'b0, ch, rg, 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise[4];
        int nrise;
        bit prev, obs, run_ok, irq_seen;

        // Reset state
        #1 reset_n = 1'b0;
        #2;
        check("reset readdata", readdata, 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        check("reset irq_vec", 32'(irq_vec), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Register-access table: readdata after each edge shows the pre-edge state
        tbl[0]  = mk(0, 0, R_PERIOD,   32'h0,        32'h00BEBC1F);
        tbl[1]  = mk(0, 0, R_STATUS,   32'h0,        32'h0);
        tbl[2]  = mk(0, 0, R_CONTROL,  32'h0,        32'h0);
        tbl[3]  = mk(0, 0, R_PRESCALE, 32'h0,        32'h0);
        tbl[4]  = mk(0, 0, R_SNAPSHOT, 32'h0,        32'h0);
        tbl[5]  = mk(0, 0, R_PENDING,  32'h0,        32'h0);
        tbl[6]  = mk(1, 0, R_PRESCALE, 32'hFFFFFF37, 32'h0);
        tbl[7]  = mk(0, 0, R_PRESCALE, 32'h0,        32'h37);
        tbl[8]  = mk(1, 0, R_CONTROL,  32'hFFFFFFF3, 32'h0);
        tbl[9]  = mk(0, 0, R_CONTROL,  32'h0,        32'h3);
        tbl[10] = mk(1, 0, 6,          32'hFFFFFFFF, 32'h0);
        tbl[11] = mk(0, 0, 6,          32'h0,        32'h0);
        tbl[12] = mk(0, 0, 7,          32'h0,        32'h0);
        tbl[13] = mk(1, 0, R_PERIOD,   32'h00001234, 32'h00BEBC1F);
        tbl[14] = mk(0, 0, R_PERIOD,   32'h0,        32'h00001234);
        tbl[15] = mk(0, 1, R_PERIOD,   32'h0,        32'h00BEBC1F);
        tbl[16] = mk(0, 3, R_PRESCALE, 32'h0,        32'h0);
        tbl[17] = mk(1, 0, R_SNAPSHOT, 32'hDEADBEEF, 32'h0);
        tbl[18] = mk(0, 0, R_SNAPSHOT, 32'h0,        32'h00001234);
        tbl[19] = mk(1, 0, R_STATUS,   32'hFFFFFFFF, 32'h0);
        tbl[20] = mk(1, 0, R_PENDING,  32'h000000FF, 32'h0);
        tbl[21] = mk(0, 0, R_STATUS,   32'h0,        32'h0);
        tbl[22] = mk(1, 0, R_CONTROL,  32'h0,        32'h3);
        tbl[23] = mk(0, 0, R_CONTROL,  32'h0,        32'h0);

        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i].w, tbl[i].ch, tbl[i].rg, tbl[i].wd);
            check($sformatf("tbl[%0d]", i), readdata, tbl[i].exp);
        end
        check("irq after table", 32'(irq), 32'h0);

        // ch1 one-shot, period 5, prescale 0, START coincident with forced reload
        wr(1, R_PRESCALE, 32'd0);
        wr(1, R_PERIOD, 32'd5);
        wr(1, R_CONTROL, 32'h5);
        for (int k = 1; k <= 6; k++) begin
            idle(1);
            check($sformatf("ch1 irq_vec +%0d", k), 32'(irq_vec), (k == 6) ? 32'h2 : 32'h0);
        end
        check("ch1 irq", 32'(irq), 32'h1);
        rd(1, R_STATUS);
        check("ch1 status after oneshot", readdata, 32'h1);
        idle(4);
        wr(1, R_SNAPSHOT, 32'h0);
        rd(1, R_SNAPSHOT);
        check("ch1 counter holds 0", readdata, 32'h0);
        wr(1, R_STATUS, 32'h1);
        check("ch1 irq cleared", 32'(irq), 32'h0);

        // ch2 continuous, period 3, prescale 1: timeout every 8 cycles, no irq
        wr(2, R_PRESCALE, 32'd1);
        wr(2, R_PERIOD, 32'd3);
        wr(2, R_CONTROL, 32'h6);
        address  = AW'(2 * 8 + R_STATUS);
        nrise    = 0;
        prev     = 1'b0;
        run_ok   = 1'b1;
        irq_seen = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(posedge clk);
            #1;
            chipselect = 1'b0;
            write_n    = 1'b1;
            obs = readdata[0];
            if (!readdata[1]) run_ok = 1'b0;
            if (irq) irq_seen = 1'b1;
            if (obs && !prev) begin
                if (nrise < 4) rise[nrise] = c;
                nrise++;
                chipselect = 1'b1;
                write_n    = 1'b0;
                writedata  = 32'h1;
            end
            prev = obs;
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("ch2 timeout count", 32'(nrise), 32'd4);
        for (int j = 0; j < 4; j++)
            check($sformatf("ch2 timeout %0d cycle", j), 32'(rise[j]), 32'(8 + 8 * j));
        check("ch2 run stays 1", 32'(run_ok), 32'h1);
        check("ch2 no irq", 32'(irq_seen), 32'h0);
        wr(2, R_CONTROL, 32'h8);
        idle(2);
        wr(2, R_STATUS, 32'h1);
        rd(2, R_STATUS);
        check("ch2 stopped and clear", readdata, 32'h0);

        // ch0: W1C clear lands on the same edge as the timeout event
        wr(0, R_PRESCALE, 32'd0);
        wr(0, R_PERIOD, 32'd3);
        wr(0, R_CONTROL, 32'h5);
        idle(3);
        wr(0, R_STATUS, 32'h1);
        check("ch0 TO survives clear (irq)", 32'(irq), 32'h1);
        check("ch0 TO survives clear (irq_vec)", 32'(irq_vec), 32'h1);
        rd(0, R_STATUS);
        check("ch0 status after race", readdata, 32'h1);
        wr(0, R_STATUS, 32'h1);
        check("ch0 irq after clear", 32'(irq), 32'h0);
        rd(0, R_STATUS);
        check("ch0 status after clear", readdata, 32'h0);

        // ch1: START+STOP together runs; PERIOD write then stops and reloads
        wr(1, R_CONTROL, 32'hC);
        rd(1, R_STATUS);
        check("ch1 start+stop runs", readdata, 32'h2);
        rd(1, R_CONTROL);
        check("ch1 control self-clear", readdata, 32'h0);
        wr(1, R_PERIOD, 32'h40);
        idle(1);
        rd(1, R_STATUS);
        check("ch1 period write stops", readdata, 32'h0);
        wr(1, R_SNAPSHOT, 32'h0);
        rd(1, R_SNAPSHOT);
        check("ch1 counter reloaded", readdata, 32'h40);

        // ch3: snapshot of a live count, then pending view across channels
        wr(3, R_PERIOD, 32'd100);
        wr(3, R_CONTROL, 32'h4);
        idle(10);
        wr(3, R_SNAPSHOT, 32'h0);
        rd(3, R_SNAPSHOT);
        check("ch3 snapshot", readdata, 32'd90);
        wr(0, R_CONTROL, 32'h5);
        idle(100);
        rd(2, R_PENDING);
        check("pending via ch2", readdata, 32'h9);
        check("pending irq_vec", 32'(irq_vec), 32'h1);
        check("pending irq", 32'(irq), 32'h1);
        rd(3, R_STATUS);
        check("ch3 status done", readdata, 32'h1);

        // Reset in the middle of a count
        wr(1, R_CONTROL, 32'h4);
        idle(5);
        #2 reset_n = 1'b0;
        #1;
        check("midreset readdata", readdata, 32'h0);
        check("midreset irq", 32'(irq), 32'h0);
        check("midreset irq_vec", 32'(irq_vec), 32'h0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle(10);
        rd(1, R_STATUS);
        check("post-reset ch1 status", readdata, 32'h0);
        rd(1, R_PERIOD);
        check("post-reset ch1 period", readdata, 32'h00BEBC1F);
        rd(0, R_PENDING);
        check("post-reset pending", readdata, 32'h0);
        check("post-reset irq", 32'(irq), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/computer_system_multi_interval_timer.md
COMPUTER_SYSTEM_MULTI_INTERVAL_TIMER -- requirements
Module: computer_system_multi_interval_timer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent timer channels, legal 1..8.
REQ-002 Parameter CNT_W, default 32: counter/period width, legal 8..32.
REQ-003 Parameter PRE_W, default 8: prescaler width, legal 1..16.
REQ-004 Parameter DEFAULT_PERIOD, default 32'h00BEBC1F: reset value of every period and counter, truncated to CNT_W.
REQ-005 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  system clock; all state changes on rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 address  in  3+clog2(NUM_CH)  {channel, reg[2:0]}.
REQ-009 chipselect  in  1  slave select.
REQ-010 write_n  in  1  active-low write strobe, qualified by chipselect.
REQ-011 writedata  in  32  write data.
REQ-012 readdata  out  32  registered read data.
REQ-013 irq  out  1  OR of all enabled pending channel interrupts.
REQ-014 irq_vec  out  NUM_CH  per-channel enabled pending interrupts.

Function
REQ-015 Per-channel register map (reg): 0 STATUS, 1 CONTROL, 2 PERIOD, 3 SNAPSHOT, 4 PRESCALE, 5 PENDING (global, same for all channels); 6-7 read 0, writes ignored.
REQ-016 STATUS read: bit0 TO (timeout occurred), bit1 RUN; write: writing 1 to bit0 clears TO (W1C), other bits ignored.
REQ-017 CONTROL bits: 0 ITO (irq enable), 1 CONT (continuous), 2 START (self-clearing, reads 0), 3 STOP (self-clearing, reads 0); bits 1:0 stored.
REQ-018 PERIOD read/write, CNT_W bits zero-extended; PRESCALE read/write, PRE_W bits; SNAPSHOT write (any data) captures live counter, read returns captured value.
REQ-019 PENDING read returns {zeros, TO[NUM_CH-1:0]}; write ignored.
REQ-020 readdata SHALL update every cycle with the mux of the addressed register (1-cycle read latency, no wait states); addresses for channels >= NUM_CH read 0.
REQ-021 Prescaler per channel: while RUN, pre_cnt counts down PRESCALE..0; tick asserted in the cycle pre_cnt==0, then reload PRESCALE; PRESCALE=0 gives tick every cycle.
REQ-022 Counter: on tick, if counter==0 reload PERIOD else decrement by 1; no change when RUN=0 except forced reload.
REQ-023 PERIOD write: next cycle forced reload of counter and pre_cnt, and RUN cleared.
REQ-024 Timeout event: counter==0 this cycle and !=0 previous cycle (edge), sets TO.
REQ-025 One-shot (CONT=0): RUN clears when counter reaches 0; counter holds 0.
REQ-026 Continuous (CONT=1): counter reloads PERIOD on the tick after reaching 0; RUN stays set.
REQ-027 Simultaneous START and STOP in one write: START wins, RUN=1.
REQ-028 START in same cycle as forced reload: RUN=1 after reload.
REQ-029 W1C clear coincident with timeout event: TO remains 1 (event not lost).
REQ-030 irq_vec[i] = TO[i] & ITO[i]; irq = |irq_vec; both combinational from registers.
REQ-031 Channels fully independent; a write affects only the addressed channel.

Reset
REQ-032 On reset_n low, immediately: readdata=0, TO=0, RUN=0, CONTROL=0, PRESCALE=0, SNAPSHOT=0, PERIOD=counter=DEFAULT_PERIOD, pre_cnt=0, edge register=0, irq=0, irq_vec=0.
REQ-033 Reset mid-count SHALL abandon the count with no timeout event on release.

Verification
REQ-034 Reset, read ch0 PERIOD -> readdata=0x00BEBC1F one cycle after address; irq=0.
REQ-035 ch1 PERIOD=5, PRESCALE=0, CONTROL=0x5 (ITO,START) -> TO and irq_vec[1] set 6 cycles after START write; RUN=0; counter holds 0.
REQ-036 ch2 PERIOD=3, PRESCALE=1, CONTROL=0x6 -> TO set on each period every 8 cycles; RUN stays 1; irq stays 0 (ITO=0).
REQ-037 ch0 running, write STATUS=1 in same cycle as timeout event -> TO remains 1; subsequent STATUS=1 -> TO=0, irq=0.
REQ-038 CONTROL=0xC (START+STOP) -> RUN=1; then PERIOD write while running -> RUN=0, counter=new PERIOD.
REQ-039 ch3 running, SNAPSHOT write, read SNAPSHOT -> value equals counter at write cycle; PENDING read reflects TO of all channels.
